// File: rtl/sseg_num_writer_if.sv
// Request/response and array-write signals between a gauge source, the
// number writer and the seven-segment digit array.
interface sseg_num_writer_if #(
    parameter int SSEG_BITS = 2,
    parameter int VAL_BITS  = 12
);
    logic                 start;
    logic [VAL_BITS-1:0]  value;
    logic                 dp_en;
    logic [SSEG_BITS-1:0] dp_pos;
    logic                 wr;
    logic [SSEG_BITS-1:0] sel;
    logic [3:0]           val;
    logic                 en;
    logic                 sign;
    logic                 dp;
    logic                 busy;
    logic                 ovf;
    logic                 done_tick;

    modport master (
        output start, value, dp_en, dp_pos,
        input  wr, sel, val, en, sign, dp, busy, ovf, done_tick
    );

    modport slave (
        input  start, value, dp_en, dp_pos,
        output wr, sel, val, en, sign, dp, busy, ovf, done_tick
    );
endinterface

// File: rtl/sseg_num_writer.sv
// Converts a signed reading to BCD by double-dabble, then writes one digit per
// cycle to the seven-segment array with blanking, minus sign and decimal point.
module sseg_num_writer #(
    parameter int SSEG_BITS = 2,
    parameter int SSEG_N    = 4,
    parameter int VAL_BITS  = 12
) (
    input  logic             clk,
    input  logic             reset,
    sseg_num_writer_if.slave bus
);
    localparam int BCD_W = 4 * (SSEG_N + 1);
    localparam int CNT_W = $clog2(VAL_BITS + 1);

    typedef enum logic [1:0] {IDLE, CONV, WRITE, DONE} state_t;

    state_t               state_q, state_d;
    logic [VAL_BITS-1:0]  mag_q, mag_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SSEG_BITS-1:0] idx_q, idx_d;
    logic [SSEG_BITS-1:0] dp_pos_q, dp_pos_d;
    logic                 neg_q, neg_d, dp_en_q, dp_en_d;
    logic                 wr_q, wr_d, en_q, en_d, sign_q, sign_d, dp_q, dp_d;
    logic                 busy_q, busy_d, ovf_q, ovf_d, done_q, done_d;
    logic [SSEG_BITS-1:0] sel_q, sel_d;
    logic [3:0]           val_q, val_d;
    logic [SSEG_BITS-1:0] msd, top;
    logic [3:0]           digit;
    logic                 ovf_now;

    // The BCD register is stable for the whole WRITE phase, so the display
    // decode is purely combinational on it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        msd   = '0;
        digit = '0;
        for (int i = 0; i < SSEG_N; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) msd = SSEG_BITS'(i);
            if (idx_q == SSEG_BITS'(i))  digit = bcd_q[4*i +: 4];
        end
        top     = (dp_en_q && dp_pos_q > msd) ? dp_pos_q : msd;
        ovf_now = (bcd_q[4*SSEG_N +: 4] != 4'd0) ||
                  (neg_q && (int'(top) + 1 > SSEG_N - 1));
    end

    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        neg_d    = neg_q;
        dp_en_d  = dp_en_q;
        dp_pos_d = dp_pos_q;
        busy_d   = busy_q;
        ovf_d    = ovf_q;
        wr_d     = 1'b0;
        sel_d    = '0;
        val_d    = '0;
        en_d     = 1'b0;
        sign_d   = 1'b0;
        dp_d     = 1'b0;
        done_d   = 1'b0;

        bcd_adj = bcd_q;
        for (int i = 0; i <= SSEG_N; i++) begin
            if (bcd_adj[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
        end

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    // Unsigned negation keeps the most negative reading representable.
                    mag_d    = bus.value[VAL_BITS-1] ? -bus.value : bus.value;
                    neg_d    = bus.value[VAL_BITS-1];
                    dp_en_d  = bus.dp_en;
                    dp_pos_d = bus.dp_pos;
                    bcd_d    = '0;
                    cnt_d    = '0;
                    idx_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = CONV;
                end
            end
            CONV: begin
                bcd_d = (bcd_adj << 1) | BCD_W'(mag_q[VAL_BITS-1]);
                mag_d = mag_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(VAL_BITS - 1)) state_d = WRITE;
            end
            WRITE: begin
                wr_d  = 1'b1;
                sel_d = idx_q;
                if (idx_q == '0) ovf_d = ovf_now;
                if (ovf_now) begin
                    en_d   = 1'b1;
                    sign_d = 1'b1;
                end else begin
                    if (idx_q <= top) begin
                        en_d  = 1'b1;
                        val_d = digit;
                    end else if (neg_q && int'(idx_q) == int'(top) + 1) begin
                        en_d   = 1'b1;
                        sign_d = 1'b1;
                    end
                    dp_d = dp_en_q && (idx_q == dp_pos_q);
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == SSEG_BITS'(SSEG_N - 1)) state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            state_q  <= IDLE;
            mag_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            neg_q    <= 1'b0;
            dp_en_q  <= 1'b0;
            dp_pos_q <= '0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wr_q     <= 1'b0;
            sel_q    <= '0;
            val_q    <= '0;
            en_q     <= 1'b0;
            sign_q   <= 1'b0;
            dp_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mag_q    <= mag_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            neg_q    <= neg_d;
            dp_en_q  <= dp_en_d;
            dp_pos_q <= dp_pos_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
            wr_q     <= wr_d;
            sel_q    <= sel_d;
            val_q    <= val_d;
            en_q     <= en_d;
            sign_q   <= sign_d;
            dp_q     <= dp_d;
            done_q   <= done_d;
        end
    end

    assign bus.wr        = wr_q;
    assign bus.sel       = sel_q;
    assign bus.val       = val_q;
    assign bus.en        = en_q;
    assign bus.sign      = sign_q;
    assign bus.dp        = dp_q;
    assign bus.busy      = busy_q;
    assign bus.ovf       = ovf_q;
    assign bus.done_tick = done_q;
endmodule

// File: tb/tb_sseg_num_writer.sv
// Scoreboard bench for sseg_num_writer: a decimal model queues the expected
// digit writes and a negedge monitor pops and compares each array write.
module tb_sseg_num_writer;
    localparam int SSEG_BITS = 2;
    localparam int SSEG_N    = 4;
    localparam int VAL_BITS  = 12;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sseg_num_writer_if #(.SSEG_BITS(SSEG_BITS), .VAL_BITS(VAL_BITS)) bus ();

    sseg_num_writer #(
        .SSEG_BITS(SSEG_BITS),
        .SSEG_N   (SSEG_N),
        .VAL_BITS (VAL_BITS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [SSEG_BITS-1:0] sel;
        logic [3:0]           val;
        logic                 en;
        logic                 sign;
        logic                 dp;
    } wr_t;

    wr_t exp_q[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  wr_seen     = 0;
    int  done_seen   = 0;

    always @(negedge clk) begin : monitor
        wr_t got, want;
        if (reset) begin
            got = {bus.sel, bus.val, bus.en, bus.sign, bus.dp};
            if (bus.done_tick === 1'b1) done_seen++;
            vectors++;
            if (bus.wr === 1'b1) begin
                wr_seen++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write: got sel=%0d val=%0d en=%0b sign=%0b dp=%0b, none expected",
                             got.sel, got.val, got.en, got.sign, got.dp);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        miscompares++;
                        $display("FAIL digit_write: got sel=%0d val=%0d en=%0b sign=%0b dp=%0b, expected sel=%0d val=%0d en=%0b sign=%0b dp=%0b",
                                 got.sel, got.val, got.en, got.sign, got.dp,
                                 want.sel, want.val, want.en, want.sign, want.dp);
                    end
                end
            end else if (got !== '0) begin
                miscompares++;
                $display("FAIL idle_bus: got %b while wr=0, expected all zero", got);
            end
        end
    end

    // Decimal reference model built directly from the display rules.
    task automatic push_expected(input int v, input logic den, input int dpos,
                                 input int n_push, output logic exp_ovf);
        int   mag, msd, top, p;
        int   d[5];
        logic neg;
        wr_t  w;
        neg = (v < 0);
        mag = neg ? -v : v;
        p   = 1;
        for (int i = 0; i < 4; i++) begin
            d[i] = (mag / p) % 10;
            p    = p * 10;
        end
        d[4] = mag / 10000;
        msd  = 0;
        for (int i = 0; i < 4; i++) if (d[i] != 0) msd = i;
        top     = (den && dpos > msd) ? dpos : msd;
        exp_ovf = (d[4] != 0) || (neg && top + 1 > SSEG_N - 1);
        for (int i = 0; i < n_push; i++) begin
            w = '0;
            w.sel = SSEG_BITS'(i);
            if (exp_ovf) begin
                w.en   = 1'b1;
                w.sign = 1'b1;
            end else begin
                if (i <= top) begin
                    w.en  = 1'b1;
                    w.val = 4'(d[i]);
                end else if (neg && i == top + 1) begin
                    w.en   = 1'b1;
                    w.sign = 1'b1;
                end
                w.dp = den && (i == dpos);
            end
            exp_q.push_back(w);
        end
    endtask

    // Starts one conversion at the current negedge and waits for done_tick.
    task automatic run_conv(input string name, input int v, input logic den,
                            input int dpos, input int glitch_at);
        logic exp_ovf;
        int   n, wr0, done0;
        push_expected(v, den, dpos, SSEG_N, exp_ovf);
        wr0          = wr_seen;
        done0        = done_seen;
        bus.start    = 1'b1;
        bus.value    = VAL_BITS'(v);
        bus.dp_en    = den;
        bus.dp_pos   = SSEG_BITS'(dpos);
        @(posedge clk);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.value  = 12'h5A5;
        bus.dp_en  = ~den;
        bus.dp_pos = ~SSEG_BITS'(dpos);
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_after_start: got %b, expected 1", name, bus.busy);
        end
        n = 0;
        while (bus.done_tick !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
            bus.start = (n == glitch_at);
        end
        bus.start = 1'b0;
        #1;
        vectors++;
        if (n != VAL_BITS + SSEG_N + 1) begin
            miscompares++;
            $display("FAIL %s done_latency: got %0d cycles, expected %0d", name, n, VAL_BITS + SSEG_N + 1);
        end
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_in_done: got %b, expected 1", name, bus.busy);
        end
        vectors++;
        if (bus.ovf !== exp_ovf) begin
            miscompares++;
            $display("FAIL %s ovf: got %b, expected %b", name, bus.ovf, exp_ovf);
        end
        vectors++;
        if (wr_seen - wr0 != SSEG_N || done_seen - done0 != 1) begin
            miscompares++;
            $display("FAIL %s pulse_count: got %0d writes %0d done, expected %0d writes 1 done",
                     name, wr_seen - wr0, done_seen - done0, SSEG_N);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s pending_writes: got %0d left, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        bus.start  = 1'b0;
        bus.value  = '0;
        bus.dp_en  = 1'b0;
        bus.dp_pos = '0;
        reset      = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.wr, bus.sel, bus.val, bus.en, bus.sign, bus.dp, bus.busy, bus.ovf, bus.done_tick} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b, expected all zero",
                     {bus.wr, bus.sel, bus.val, bus.en, bus.sign, bus.dp, bus.busy, bus.ovf, bus.done_tick});
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_conv("pos_123", 123, 1'b0, 0, -1);
        run_conv("neg_45", -45, 1'b0, 0, -1);
        run_conv("dp_7", 7, 1'b1, 2, -1);
    endtask

    task automatic test_overflow();
        run_conv("neg_1000", -1000, 1'b0, 0, -1);
        run_conv("neg_2048", -2048, 1'b0, 0, -1);
        run_conv("pos_2047", 2047, 1'b0, 0, -1);
        run_conv("neg_5_dp3", -5, 1'b1, 3, -1);
    endtask

    task automatic test_zero_ignored_start();
        int wr0, done0;
        run_conv("zero_glitch", 0, 1'b0, 0, 3);
        wr0   = wr_seen;
        done0 = done_seen;
        repeat (20) @(negedge clk);
        #1;
        vectors++;
        if (wr_seen != wr0 || done_seen != done0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_start: got %0d extra writes %0d extra done busy=%b, expected 0 0 0",
                     wr_seen - wr0, done_seen - done0, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        run_conv("b2b_neg_999", -999, 1'b0, 0, -1);
        run_conv("b2b_999", 999, 1'b0, 0, -1);
        run_conv("b2b_5_dp3", 5, 1'b1, 3, -1);
    endtask

    task automatic test_reset_mid_write();
        logic exp_ovf;
        int   done0;
        @(negedge clk);
        push_expected(456, 1'b0, 0, 1, exp_ovf);
        done0      = done_seen;
        bus.start  = 1'b1;
        bus.value  = VAL_BITS'(456);
        bus.dp_en  = 1'b0;
        bus.dp_pos = '0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (VAL_BITS + 2) @(posedge clk);
        #1;
        vectors++;
        if (bus.wr !== 1'b1 || bus.sel !== SSEG_BITS'(1)) begin
            miscompares++;
            $display("FAIL second_write: got wr=%b sel=%0d, expected wr=1 sel=1", bus.wr, bus.sel);
        end
        #1 reset = 1'b0;
        #1;
        vectors++;
        if ({bus.wr, bus.busy, bus.done_tick, bus.ovf} !== 4'b0000) begin
            miscompares++;
            $display("FAIL async_reset: got wr=%b busy=%b done=%b ovf=%b, expected all 0",
                     bus.wr, bus.busy, bus.done_tick, bus.ovf);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (25) @(negedge clk);
        vectors++;
        if (done_seen != done0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL aborted_sequence: got %0d done %0d pending, expected 0 0",
                     done_seen - done0, exp_q.size());
            exp_q.delete();
        end
        run_conv("after_reset_9", 9, 1'b0, 0, -1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_zero_ignored_start();
        test_back_to_back();
        test_reset_mid_write();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sseg_num_writer.md
Name: sseg_num_writer

Overview:
- Upstream feeder for the seven-segment display array.
- Accepts a signed binary gauge reading (boost, AFR, etc.) on a start pulse and converts it to BCD with a shift-add-3 (double-dabble) sequencer.
- Applies leading-zero blanking, minus-sign placement and decimal point.
- Issues one array write per digit (wr/sel/val/en/sign/dp), then pulses done_tick.

Parameters:
- SSEG_BITS, 2, width of the digit-select bus; must satisfy 2^SSEG_BITS >= SSEG_N.
- SSEG_N, 4, number of digits driven; digit 0 is least significant.
- VAL_BITS, 12, width of the two's-complement input value.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- value  input  VAL_BITS  signed reading, captured when start is accepted.
- dp_en  input  1  enable the decimal point; captured with value.
- dp_pos  input  SSEG_BITS  digit index that carries the dp; captured with value.
- wr  output  1  write strobe to the array, one cycle per digit.
- sel  output  SSEG_BITS  digit index for the current write.
- val  output  4  BCD digit for the current write.
- en  output  1  digit enable (0 = blank).
- sign  output  1  digit shows a minus sign; overrides val.
- dp  output  1  decimal point for the current digit.
- busy  output  1  high from accepted start through the done_tick cycle.
- ovf  output  1  registered; 1 if the last conversion overflowed.
- done_tick  output  1  one-cycle pulse after the last write.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: wr, sel, val, en, sign, dp, busy, ovf, done_tick.
  - Internal BCD and shift registers are cleared.
- Reset mid-operation: the sequence is abandoned, wr drops immediately, and no done_tick is produced.
- States: IDLE -> CONV -> WRITE -> DONE -> IDLE.
- IDLE:
  - On start=1, capture value, dp_en and dp_pos.
  - Compute magnitude = |value| as an unsigned VAL_BITS quantity, so the most negative value is handled.
  - Latch neg = value[VAL_BITS-1] and go to CONV.
  - start while not in IDLE is ignored; there is no queuing.
- CONV:
  - Exactly VAL_BITS cycles of add-3-then-shift into SSEG_N+1 BCD nibbles; the extra nibble detects overflow.
  - At exit, compute msd = index of the highest nonzero BCD digit (0 if the value is 0).
  - Compute top = max(msd, dp_pos if dp_en else 0).
- Overflow:
  - Positive overflow: nibble SSEG_N is nonzero.
  - Negative overflow: neg=1 and top+1 > SSEG_N-1.
  - On overflow, ovf=1 and every digit is written with en=1, sign=1, val=0, dp=0 (all dashes).
  - ovf is updated at CONV exit and held until the next conversion.
- WRITE: SSEG_N consecutive cycles with wr=1 and sel = 0,1,...,SSEG_N-1. For digit i, no overflow:
  - i <= top: en=1, val=BCD[i], sign=0.
  - neg and i == top+1: en=1, sign=1, val=0.
  - Otherwise: en=0, val=0, sign=0.
  - dp=1 only when dp_en and i == dp_pos.
- DONE: done_tick=1 for one cycle, wr=0; return to IDLE. busy falls with the return to IDLE.
- Timing:
  - start accepted on edge k.
  - wr is high on cycles k+VAL_BITS+1 through k+VAL_BITS+SSEG_N.
  - done_tick is high on cycle k+VAL_BITS+SSEG_N+1; defaults give 17 cycles.
  - A new start is accepted on the cycle after done_tick.
- sel, val, en, sign and dp are valid only while wr=1; they are driven to 0 otherwise.
- Value 0 displays a single "0" on digit 0; digits 1..SSEG_N-1 are blank.

Test Plan:
1. value=123, dp_en=0 -> writes are (sel0,3,en1), (sel1,2,en1), (sel2,1,en1), (sel3,en0); sign=0 throughout; done_tick exactly 17 cycles after start; ovf=0.
2. value=-45 -> (sel0,5,en1), (sel1,4,en1), (sel2,en1,sign1), (sel3,en0); ovf=0.
3. value=7, dp_en=1, dp_pos=2 -> (sel0,7), (sel1,0,en1), (sel2,0,en1,dp1), (sel3,en0); dp high only on sel2.
4. value=-1000 and value=-2048 -> ovf=1; all four writes en=1, sign=1. Then value=2047 -> 2,0,4,7 on sel3..0, ovf cleared to 0.
5. value=0, with a second start pulsed during CONV -> (sel0,0,en1), sel1..3 en0; exactly 4 wr pulses and one done_tick; the second start has no effect.
6. Assert reset during the second WRITE cycle -> wr, busy and done_tick are 0 immediately; after release, value=9 completes normally with a single done_tick.
